mac_feeder: RTL
===============

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter N, default 3: systolic array dimension (supported 2..4); feeds an N x N grid of MAC cells.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  write request for one matrix element.
REQ-005 load_ready  output  1  high when writes are accepted.
REQ-006 load_sel  input  1  target matrix: 0 = A, 1 = B.
REQ-007 load_idx  input  4  row-major element index (row*N + col).
REQ-008 load_data  input  8  element value, 8-bit minifloat {sign, exp[2:0] bias 3, frac[3:0]}, stored verbatim.
REQ-009 start  input  1  begin streaming the stored matrices.
REQ-010 busy  output  1  high during STREAM and DRAIN.
REQ-011 done  output  1  one-cycle pulse; all MAC accumulators final.
REQ-012 a_edge  output  N*8  left-edge ain lanes; lane i = bits [8i+7:8i] drives row i.
REQ-013 b_edge  output  N*8  top-edge bin lanes; lane j = bits [8j+7:8j] drives column j.

Function
REQ-014 Block SHALL hold two N*N x 8 register files, A and B. It SHALL perform no arithmetic on element values.
REQ-015 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-016 IDLE: load_ready=1, busy=0, done=0, a_edge=b_edge=0.
REQ-017 In IDLE, load_valid=1 with load_idx < N*N SHALL write load_data into the selected file at that edge. load_idx >= N*N SHALL be ignored.
REQ-018 load_valid outside IDLE SHALL be ignored (load_ready=0); memories unchanged.
REQ-019 start=1 in IDLE SHALL move to STREAM with counter t=0. start in any other state SHALL be ignored.
REQ-020 If load_valid and start are both high in IDLE, the write SHALL commit and the stream SHALL use the updated value.
REQ-021 STREAM covers t = 0..2N-2, one cycle per t.
- a_edge lane i = A[i][t-i] when 0 <= t-i < N, else 8'h00.
- b_edge lane j = B[t-j][j] when 0 <= t-j < N, else 8'h00.
REQ-022 Outputs SHALL be registered; the value for cycle t is present throughout the cycle in which state=STREAM and counter=t.
REQ-023 DRAIN SHALL last N-1 cycles (t = 2N-1..3N-3) with a_edge=b_edge=0, then go to DONE.
REQ-024 DONE SHALL last exactly one cycle: done=1, busy=0, load_ready=0, outputs 0. Next state IDLE.
REQ-025 start-to-done latency SHALL be fixed: busy high for 3N-2 cycles, done in the following cycle.
REQ-026 Memories SHALL retain contents across runs; repeated start without loads SHALL replay identical streams.

Reset
REQ-027 rst=1 at any edge (including mid-STREAM or DRAIN) SHALL force IDLE, t=0, a_edge=b_edge=0, busy=0, done=0, load_ready=1, and clear both memories to 8'h00.
REQ-028 rst SHALL take priority over start and load_valid in the same cycle. An interrupted run SHALL NOT produce done.

Verification (N=3; A[i][k]=i*3+k+1, i.e. 0x01..0x09; B[k][j]=0x11+k*3+j)
REQ-029 Assert rst one cycle:
- busy=0, done=0, load_ready=1, a_edge=b_edge=0.
- A subsequent start streams all zeros.
REQ-030 Load both matrices, pulse start:
- t=0: a lanes {0x01,0,0}; b lanes {0x11,0,0}.
- t=2: a lanes {0x03,0x05,0x07}; b lanes {0x17,0x15,0x13}.
- t=4: a lanes {0,0,0x09}; b lanes {0,0,0x19}.
REQ-031 Same run timing:
- busy high exactly 7 cycles; outputs zero at t=5,6.
- done high exactly in the 8th cycle after start, then IDLE with load_ready=1.
REQ-032 During busy, pulse start and write A idx0=0xAA:
- No effect on the current run; load_ready=0.
- Rerun shows lane0 t=0 = 0x01.
REQ-033 Assert rst at t=2:
- Next cycle outputs 0, busy=0, no done pulse.
- Rerun after reset streams zeros.
REQ-034 In IDLE, drive load_valid (A, idx0, 0x55) and start in the same cycle:
- t=0 a lane0 = 0x55.
- Separately, a write with load_idx=9 leaves all entries unchanged.

Source files
------------

// File: rtl/mac_feeder.sv
// Feeds skewed A rows / B columns into the left and top edges of an N x N systolic MAC grid.
// Latency: first lanes valid in the cycle after start; busy for 3N-2 cycles, then a one-cycle done.
// Backpressure: load_ready is high only in IDLE; loads and start are dropped while a run is in flight.
module mac_feeder #(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic           load_sel,
    input  logic [3:0]     load_idx,
    input  logic [7:0]     load_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [N*8-1:0] a_edge,
    output logic [N*8-1:0] b_edge
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam int         NE            = N * N;
    localparam logic [3:0] T_STREAM_LAST = 4'(2 * N - 2);
    localparam logic [3:0] T_DRAIN_LAST  = 4'(3 * N - 3);

    state_t         state, state_nxt;
    logic [3:0]     t, t_nxt;
    logic [7:0]     a_mem     [NE];
    logic [7:0]     b_mem     [NE];
    logic [7:0]     a_mem_nxt [NE];
    logic [7:0]     b_mem_nxt [NE];
    logic [N*8-1:0] a_edge_nxt, b_edge_nxt;

    // Sequencer: IDLE -> STREAM (t=0..2N-2) -> DRAIN (t=2N-1..3N-3) -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    t_nxt     = '0;
                end
            end
            STREAM: begin
                t_nxt = t + 4'd1;
                if (t == T_STREAM_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (t == T_DRAIN_LAST) begin
                    state_nxt = DONE;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                t_nxt     = '0;
            end
            default: begin
                state_nxt = IDLE;
                t_nxt     = '0;
            end
        endcase
    end

    // Register-file write path; out-of-range indices match no entry and are dropped.
    always_comb begin
        for (int e = 0; e < NE; e++) begin
            a_mem_nxt[e] = a_mem[e];
            b_mem_nxt[e] = b_mem[e];
        end
        if (state == IDLE && load_valid) begin
            for (int e = 0; e < NE; e++) begin
                if (load_idx == 4'(e)) begin
                    if (load_sel) b_mem_nxt[e] = load_data;
                    else          a_mem_nxt[e] = load_data;
                end
            end
        end
    end

    // Lane selection for the upcoming cycle; reads the post-write view so a load
    // coinciding with start is already visible at t=0. Row i / column k meet at t=i+k.
    always_comb begin
        a_edge_nxt = '0;
        b_edge_nxt = '0;
        if (state_nxt == STREAM) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_nxt) == i + k) begin
                        a_edge_nxt[8*i +: 8] = a_mem_nxt[i*N + k];
                        b_edge_nxt[8*k +: 8] = b_mem_nxt[i*N + k];
                    end
                end
            end
        end
    end

    // State, counter, registered outputs and both register files.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            a_edge     <= '0;
            b_edge     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
            for (int e = 0; e < NE; e++) begin
                a_mem[e] <= 8'h00;
                b_mem[e] <= 8'h00;
            end
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            a_edge     <= a_edge_nxt;
            b_edge     <= b_edge_nxt;
            busy       <= (state_nxt == STREAM) || (state_nxt == DRAIN);
            done       <= (state_nxt == DONE);
            load_ready <= (state_nxt == IDLE);
            for (int e = 0; e < NE; e++) begin
                a_mem[e] <= a_mem_nxt[e];
                b_mem[e] <= b_mem_nxt[e];
            end
        end
    end

endmodule
